// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with a store buffer.
// Serves MEM-stage loads/stores and talks to word-wide backing memory over req/ack.
module data_cache_responder #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned WB_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_r_en,
    input  logic [3:0]  cpu_w_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        data_cache_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - INDEX_BITS;
    localparam int unsigned WB_AW = $clog2(WB_DEPTH);
    localparam int unsigned PTR_W = WB_AW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_FILL = 2'd2} state_e;
    state_e state_q, state_d;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [29:0]      wb_addr_q [WB_DEPTH];
    logic [31:0]      wb_data_q [WB_DEPTH];
    logic [3:0]       wb_strb_q [WB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [29:0]      miss_addr_q, miss_addr_d;

    logic [INDEX_BITS-1:0] cpu_idx, line_idx;
    logic [TAG_W-1:0]      cpu_tag, line_tag;
    logic [WB_AW-1:0]      wb_head, wb_tail;
    logic                  hit, wb_empty, wb_full;
    logic                  drain_c, fill_c, pop_c, push_c, load_miss_c, fill_done_c;
    logic                  line_we;
    logic [31:0]           line_data, merge_data;
    logic                  addr_lsb_unused;

    assign cpu_idx         = cpu_addr[INDEX_BITS+1:2];
    assign cpu_tag         = cpu_addr[31:INDEX_BITS+2];
    assign addr_lsb_unused = ^cpu_addr[1:0];
    assign hit             = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign wb_head         = rd_ptr_q[WB_AW-1:0];
    assign wb_tail         = wr_ptr_q[WB_AW-1:0];
    assign wb_empty        = (wr_ptr_q == rd_ptr_q);
    assign wb_full         = (wr_ptr_q[WB_AW] != rd_ptr_q[WB_AW]) && (wb_tail == wb_head);

    // Handshake qualifiers, buffer pointer updates and line-write selection
    always_comb begin
        drain_c     = (state_q != S_FILL) && !wb_empty;
        fill_c      = (state_q == S_FILL);
        pop_c       = drain_c && mem_ack;
        fill_done_c = fill_c && mem_ack;
        load_miss_c = (state_q == S_IDLE) && cpu_r_en && !hit;
        push_c      = (state_q == S_IDLE) && !cpu_r_en && (cpu_w_en != 4'b0000)
                      && (!wb_full || pop_c);

        for (int b = 0; b < 4; b++) begin
            merge_data[8*b +: 8] = cpu_w_en[b] ? cpu_wdata[8*b +: 8] : data_q[cpu_idx][8*b +: 8];
        end

        line_we   = 1'b0;
        line_idx  = cpu_idx;
        line_tag  = cpu_tag;
        line_data = merge_data;
        if (fill_done_c) begin
            line_we   = 1'b1;
            line_idx  = miss_addr_q[INDEX_BITS-1:0];
            line_tag  = miss_addr_q[29:INDEX_BITS];
            line_data = mem_rdata;
        end else if (push_c && hit) begin
            line_we = 1'b1;
        end

        valid_d = valid_q;
        if (line_we) begin
            valid_d[line_idx] = 1'b1;
        end
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        miss_addr_d = load_miss_c ? cpu_addr[31:2] : miss_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A miss must see every older store reach memory before its fill is issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_miss_c) state_d = (rd_ptr_d == wr_ptr_q) ? S_FILL : S_DRAIN;
            S_DRAIN: if (rd_ptr_d == wr_ptr_q) state_d = S_FILL;
            S_FILL:  if (mem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_wstrb        = 4'b0000;
        mem_addr         = 32'h0;
        mem_wdata        = 32'h0;
        data_cache_ready = 1'b1;
        cpu_rdata        = 32'h0;
        if (fill_c) begin
            mem_req  = 1'b1;
            mem_addr = {miss_addr_q, 2'b00};
        end else if (drain_c) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wstrb = wb_strb_q[wb_head];
            mem_addr  = {wb_addr_q[wb_head], 2'b00};
            mem_wdata = wb_data_q[wb_head];
        end
        if (cpu_r_en) begin
            data_cache_ready = (state_q == S_IDLE) && hit;
            if ((state_q == S_IDLE) && hit) begin
                cpu_rdata = data_q[cpu_idx];
            end
        end else if (cpu_w_en != 4'b0000) begin
            data_cache_ready = push_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            miss_addr_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Storage arrays carry no reset; valid bits and pointers qualify them
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= line_data;
        end
        if (push_c) begin
            wb_addr_q[wb_tail] <= cpu_addr[31:2];
            wb_data_q[wb_tail] <= cpu_wdata;
            wb_strb_q[wb_tail] <= cpu_w_en;
        end
    end

endmodule

// File: tb/tb_data_cache_responder.sv
// Directed bench for data_cache_responder: bench-side timing plays backing memory.
module tb_data_cache_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_r_en = 1'b0;
    logic [3:0]  cpu_w_en = 4'b0000;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        data_cache_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] conf_addr [3] = '{32'h000, 32'h100, 32'h000};
    logic [31:0] conf_data [3] = '{32'h11111111, 32'hDEADBE55, 32'h11111111};

    data_cache_responder #(.INDEX_BITS(6), .WB_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_r_en(cpu_r_en), .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .data_cache_ready(data_cache_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        next_cyc(); #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h want 0", mem_we); end
        n_checks++; if (mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_wstrb: got %0h want 0", mem_wstrb); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %0h want 0", mem_wdata); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %0h want 0", cpu_rdata); end
        n_checks++; if (data_cache_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0h want 1", data_cache_ready); end
        next_cyc(); rst = 1'b0;
    endtask

    task automatic test_cold_load();
        next_cyc(); cpu_r_en = 1'b1; cpu_addr = 32'h100; #1;
        n_checks++; if (data_cache_ready !== 1'b0) begin n_fail++; $display("FAIL cold_miss_ready: got %0h want 0", data_cache_ready); end
        next_cyc(); #1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL cold_fill_req: got req=%0h we=%0h addr=%0h want 1/0/100", mem_req, mem_we, mem_addr); end
        next_cyc(); next_cyc(); #1;
        n_checks++; if (data_cache_ready !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL cold_wait: got ready=%0h req=%0h want 0/1", data_cache_ready, mem_req); end
        next_cyc(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        n_checks++; if (data_cache_ready !== 1'b0) begin n_fail++; $display("FAIL cold_ack_ready: got %0h want 0", data_cache_ready); end
        next_cyc(); mem_ack = 1'b0; #1;
        n_checks++; if (data_cache_ready !== 1'b1) begin n_fail++; $display("FAIL cold_after_ready: got %0h want 1", data_cache_ready); end
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cold_rdata: got %0h want deadbeef", cpu_rdata); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_drop: got %0h want 0", mem_req); end
        next_cyc(); cpu_r_en = 1'b0;
        next_cyc(); cpu_r_en = 1'b1; cpu_addr = 32'h100; #1;
        n_checks++; if (data_cache_ready !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL repeat_hit: got ready=%0h rdata=%0h want 1/deadbeef", data_cache_ready, cpu_rdata); end
        next_cyc(); cpu_r_en = 1'b0;
    endtask

    task automatic test_store_hit();
        next_cyc(); cpu_w_en = 4'b0001; cpu_wdata = 32'h55; cpu_addr = 32'h100; #1;
        n_checks++; if (data_cache_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready: got %0h want 1", data_cache_ready); end
        next_cyc(); cpu_w_en = 4'b0000; cpu_r_en = 1'b1; #1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0001 || mem_addr !== 32'h100 || mem_wdata !== 32'h55) begin
            n_fail++; $display("FAIL store_write: got req=%0h we=%0h strb=%0h addr=%0h data=%0h want 1/1/1/100/55",
                               mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata); end
        n_checks++; if (data_cache_ready !== 1'b1 || cpu_rdata !== 32'hDEADBE55) begin
            n_fail++; $display("FAIL store_merge: got ready=%0h rdata=%0h want 1/deadbe55", data_cache_ready, cpu_rdata); end
        mem_ack = 1'b1;
        next_cyc(); mem_ack = 1'b0; cpu_r_en = 1'b0; #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL store_popped: got req=%0h want 0", mem_req); end
    endtask

    task automatic test_drain_before_fill();
        next_cyc(); cpu_w_en = 4'hF; cpu_wdata = 32'hCAFEF00D; cpu_addr = 32'h200; #1;
        n_checks++; if (data_cache_ready !== 1'b1) begin n_fail++; $display("FAIL drain_store_ready: got %0h want 1", data_cache_ready); end
        next_cyc(); cpu_w_en = 4'b0000; cpu_r_en = 1'b1; #1;
        n_checks++; if (data_cache_ready !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200) begin
            n_fail++; $display("FAIL drain_first: got ready=%0h req=%0h we=%0h addr=%0h want 0/1/1/200",
                               data_cache_ready, mem_req, mem_we, mem_addr); end
        next_cyc(); #1;
        n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D || data_cache_ready !== 1'b0) begin
            n_fail++; $display("FAIL drain_hold: got we=%0h wdata=%0h ready=%0h want 1/cafef00d/0", mem_we, mem_wdata, data_cache_ready); end
        mem_ack = 1'b1;
        next_cyc(); mem_ack = 1'b0; #1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200 || data_cache_ready !== 1'b0) begin
            n_fail++; $display("FAIL drain_then_fill: got req=%0h we=%0h addr=%0h ready=%0h want 1/0/200/0",
                               mem_req, mem_we, mem_addr, data_cache_ready); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        next_cyc(); mem_ack = 1'b0; #1;
        n_checks++; if (data_cache_ready !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL drain_load_done: got ready=%0h rdata=%0h want 1/cafef00d", data_cache_ready, cpu_rdata); end
        next_cyc(); cpu_r_en = 1'b0;
    endtask

    task automatic test_wb_full();
        for (int k = 0; k < 4; k++) begin
            next_cyc(); cpu_w_en = 4'hF; cpu_addr = 32'h300 + 32'(4 * k); cpu_wdata = 32'hA0 + 32'(k); #1;
            n_checks++; if (data_cache_ready !== 1'b1) begin n_fail++; $display("FAIL full_push%0d: got %0h want 1", k, data_cache_ready); end
        end
        next_cyc(); cpu_addr = 32'h310; cpu_wdata = 32'hA4; #1;
        n_checks++; if (data_cache_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: got %0h want 0", data_cache_ready); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            n_fail++; $display("FAIL full_head: got req=%0h addr=%0h want 1/300", mem_req, mem_addr); end
        next_cyc(); #1;
        n_checks++; if (data_cache_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall_hold: got %0h want 0", data_cache_ready); end
        next_cyc(); mem_ack = 1'b1; #1;
        n_checks++; if (data_cache_ready !== 1'b1) begin n_fail++; $display("FAIL full_push_on_pop: got %0h want 1", data_cache_ready); end
        next_cyc(); mem_ack = 1'b0; cpu_w_en = 4'b0000; #1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 + 32'(4 * k) || mem_wdata !== 32'hA0 + 32'(k)) begin
                n_fail++; $display("FAIL full_drain%0d: got req=%0h addr=%0h data=%0h want 1/%0h/%0h",
                                   k, mem_req, mem_addr, mem_wdata, 32'h300 + 32'(4 * k), 32'hA0 + 32'(k)); end
            mem_ack = 1'b1;
            next_cyc(); mem_ack = 1'b0; #1;
        end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_empty: got req=%0h want 0", mem_req); end
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 3; i++) begin
            next_cyc(); cpu_r_en = 1'b1; cpu_addr = conf_addr[i]; #1;
            n_checks++; if (data_cache_ready !== 1'b0) begin n_fail++; $display("FAIL conflict_miss%0d: got ready=%0h want 0", i, data_cache_ready); end
            next_cyc(); #1;
            n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== conf_addr[i]) begin
                n_fail++; $display("FAIL conflict_fill%0d: got req=%0h we=%0h addr=%0h want 1/0/%0h",
                                   i, mem_req, mem_we, mem_addr, conf_addr[i]); end
            mem_ack = 1'b1; mem_rdata = conf_data[i];
            next_cyc(); mem_ack = 1'b0; #1;
            n_checks++; if (data_cache_ready !== 1'b1 || cpu_rdata !== conf_data[i]) begin
                n_fail++; $display("FAIL conflict_data%0d: got ready=%0h rdata=%0h want 1/%0h", i, data_cache_ready, cpu_rdata, conf_data[i]); end
            next_cyc(); cpu_r_en = 1'b0;
        end
    endtask

    task automatic test_priority();
        next_cyc(); cpu_r_en = 1'b1; cpu_w_en = 4'hF; cpu_wdata = 32'hBAD0BAD0; cpu_addr = 32'h000; #1;
        n_checks++; if (data_cache_ready !== 1'b1 || cpu_rdata !== 32'h11111111) begin
            n_fail++; $display("FAIL prio_load: got ready=%0h rdata=%0h want 1/11111111", data_cache_ready, cpu_rdata); end
        next_cyc(); cpu_r_en = 1'b0; cpu_w_en = 4'b0000; mem_ack = 1'b1; #1;
        n_checks++; if (mem_req !== 1'b0 || data_cache_ready !== 1'b1) begin
            n_fail++; $display("FAIL prio_no_push: got req=%0h ready=%0h want 0/1", mem_req, data_cache_ready); end
        next_cyc(); mem_ack = 1'b0; cpu_r_en = 1'b1; #1;
        n_checks++; if (mem_req !== 1'b0 || data_cache_ready !== 1'b1 || cpu_rdata !== 32'h11111111) begin
            n_fail++; $display("FAIL prio_stray_ack: got req=%0h ready=%0h rdata=%0h want 0/1/11111111",
                               mem_req, data_cache_ready, cpu_rdata); end
        next_cyc(); cpu_r_en = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        next_cyc(); cpu_w_en = 4'hF; cpu_wdata = 32'h44; cpu_addr = 32'h400; #1;
        n_checks++; if (data_cache_ready !== 1'b1) begin n_fail++; $display("FAIL rst_store: got %0h want 1", data_cache_ready); end
        next_cyc(); cpu_w_en = 4'b0000; cpu_r_en = 1'b1; cpu_addr = 32'h500;
        next_cyc(); mem_ack = 1'b1;
        next_cyc(); mem_ack = 1'b0; #1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h500) begin
            n_fail++; $display("FAIL rst_in_fill: got req=%0h we=%0h addr=%0h want 1/0/500", mem_req, mem_we, mem_addr); end
        next_cyc(); cpu_r_en = 1'b0; rst = 1'b1; #1;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || data_cache_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_drop: got req=%0h addr=%0h ready=%0h want 0/0/1", mem_req, mem_addr, data_cache_ready); end
        next_cyc(); rst = 1'b0;
        next_cyc(); #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_wb_empty: got req=%0h want 0", mem_req); end
        cpu_r_en = 1'b1; cpu_addr = 32'h000; #1;
        n_checks++; if (data_cache_ready !== 1'b0) begin n_fail++; $display("FAIL rst_inval0: got ready=%0h want 0", data_cache_ready); end
        cpu_addr = 32'h100; #1;
        n_checks++; if (data_cache_ready !== 1'b0) begin n_fail++; $display("FAIL rst_inval100: got ready=%0h want 0", data_cache_ready); end
        next_cyc(); #1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL rst_refill: got req=%0h we=%0h addr=%0h want 1/0/100", mem_req, mem_we, mem_addr); end
        cpu_r_en = 1'b0; rst = 1'b1;
        next_cyc(); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_drain_before_fill();
        test_wb_full();
        test_conflict();
        test_priority();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
